vgacon_text_sequencer: RTL

//  Console write engine for the VGA text console peripheral. Accepts character/control commands

---
 rtl/vgacon_text_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/vgacon_text_sequencer.sv
// ---------------------------------------------------------------------------
// vgacon_text_sequencer
//   Console write engine for the VGA text console. Character and control
//   commands arrive through a small FIFO. The engine tracks a cursor and
//   drives the text buffer write port. It handles plain writes, newline,
//   carriage return, backspace, form-feed clear, and scroll-up when output
//   runs past the last row. Direct host writes share the buffer write port
//   and always take priority.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   command input, 9 bits {color[1:0], ascii[6:0]}
//   cmd_data          command payload
//   host_we/addr/     direct host buffer write; stalls the engine that cycle
//   host_wdata
//   buf_we/waddr/     buffer write port (host or engine)
//   buf_wdata
//   buf_raddr         buffer read address, used only by the scroll copy
//   buf_rdata         buffer read data, combinational from buf_raddr
//   cursor_row/col    current cursor position
//   busy              engine not idle or commands still queued
//
// Handshake: a command is accepted on every rising edge where
//   cmd_valid && cmd_ready. cmd_ready depends only on the FIFO level, never
//   on cmd_valid. Once cmd_valid is asserted, it and cmd_data must stay
//   stable until the command is accepted.
// ---------------------------------------------------------------------------
module vgacon_text_sequencer #(
  parameter int NUM_ROWS   = 3,
  parameter int NUM_COLS   = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_data,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [8:0]        host_wdata,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W:0]    FULL_LVL      = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] LAST_COPY     = ADDR_W'((NUM_ROWS-1)*NUM_COLS-1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((NUM_ROWS-1)*NUM_COLS);
  localparam logic [ADDR_W-1:0] LAST_COL_IDX  = ADDR_W'(NUM_COLS-1);
  localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(NUM_ROWS*NUM_COLS-1);
  localparam logic [1:0]        LAST_ROW      = 2'(NUM_ROWS-1);
  localparam logic [3:0]        LAST_COL      = 4'(NUM_COLS-1);
  localparam logic [8:0]        BLANK         = 9'h020;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCROLL  = 2'd1,
    CLRLINE = 2'd2,
    CLRALL  = 2'd3
  } state_t;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             fifo_empty, fifo_full, push, pop;
  logic [8:0]       head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_LVL);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr_q];

  // Storage needs no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_data;
  end

  // --------------------------------------------------------- engine state
  logic [1:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cursor_addr;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_waddr;
  logic [8:0]        eng_wdata;
  logic              nl;

  assign cursor_addr = ADDR_W'(row_q) * ROW_STRIDE + ADDR_W'(col_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    eng_we    = 1'b0;
    eng_waddr = '0;
    eng_wdata = '0;
    buf_raddr = '0;
    nl        = 1'b0;

    // A host write freezes the engine for the whole cycle.
    if (!host_we) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            case (head[6:0])
              7'h0A: nl = 1'b1;
              7'h0D: col_d = '0;
              7'h08: if (col_q != '0) col_d = col_q - 4'd1;
              7'h0C: begin
                state_d = CLRALL;
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
              end
              default: begin
                eng_we    = 1'b1;
                eng_waddr = cursor_addr;
                eng_wdata = head;
                // Writing the last column wraps exactly like a newline.
                if (col_q == LAST_COL) nl = 1'b1;
                else                   col_d = col_q + 4'd1;
              end
            endcase
            if (nl) begin
              col_d = '0;
              if (row_q < LAST_ROW) begin
                row_d = row_q + 2'd1;
              end else begin
                state_d = SCROLL;
                idx_d   = '0;
              end
            end
          end
        end
        SCROLL: begin
          // Copy cell i+NUM_COLS down to cell i using the async read port.
          buf_raddr = idx_q + ROW_STRIDE;
          eng_we    = 1'b1;
          eng_waddr = idx_q;
          eng_wdata = buf_rdata;
          if (idx_q == LAST_COPY) begin
            state_d = CLRLINE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        CLRLINE: begin
          eng_we    = 1'b1;
          eng_waddr = LAST_ROW_BASE + idx_q;
          eng_wdata = BLANK;
          if (idx_q == LAST_COL_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        CLRALL: begin
          eng_we    = 1'b1;
          eng_waddr = idx_q;
          eng_wdata = BLANK;
          if (idx_q == LAST_CELL) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  assign buf_we     = host_we || eng_we;
  assign buf_waddr  = host_we ? host_addr  : eng_waddr;
  assign buf_wdata  = host_we ? host_wdata : eng_wdata;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule
